// File: rtl/isp_pkg.sv
// Shared ISP encodings: median filter modes and frame controller states.
package isp_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS       = 2'd0,
        MODE_MEDIAN       = 2'd1,
        MODE_BORDER_CONST = 2'd2,
        MODE_BORDER_RAW   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DONE  = 2'd2,
        WAIT  = 2'd3
    } state_e;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register for the hsync/vsync/DE/pixel bundle.
module sync_delay #(
    parameter int DEPTH = 3,
    parameter int W     = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [DEPTH-1:0][W-1:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/median_frame_ctrl.sv
// Frame controller around the 3x3 median datapath: sync alignment,
// position tracking, frame-boundary config and line-length checking.
module median_frame_ctrl
    import isp_pkg::*;
#(
    parameter int          H_ACTIVE   = 1280,
    parameter int          V_ACTIVE   = 720,
    parameter int          PIPE_LAT   = 3,
    parameter logic [7:0]  BORDER_VAL = 8'd0,
    parameter int          CW         = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hsync_i,
    input  logic          vsync_i,
    input  logic          de_i,
    input  logic [7:0]    data_i,
    input  logic [7:0]    filt_data_i,
    input  logic [1:0]    cfg_mode,
    input  logic          cfg_load,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic [7:0]    data_o,
    output logic [CW-1:0] col_o,
    output logic [CW-1:0] row_o,
    output logic          frame_done,
    output logic          err_line,
    output logic          err_sticky,
    output logic          busy
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] H_LEN   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_ACTIVE - 1);

    logic [10:0] dly_in;
    logic [10:0] dly_out;
    logic        d_hs;
    logic        d_vs;
    logic        d_de;
    logic [7:0]  d_raw;

    assign dly_in = {hsync_i, vsync_i, de_i, data_i};

    sync_delay #(
        .DEPTH (PIPE_LAT),
        .W     (11)
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .d_i (dly_in),
        .q_o (dly_out)
    );

    assign {d_hs, d_vs, d_de, d_raw} = dly_out;

    logic vs_prev_q;
    logic de_prev_q;
    logic vs_rise;
    logic de_fall;

    assign vs_rise = d_vs & ~vs_prev_q;
    assign de_fall = ~d_de & de_prev_q;

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    mode_e         mode_q, mode_d;
    mode_e         pmode_q, pmode_d;
    logic          pend_q, pend_d;
    state_e        state_q, state_d;
    logic          sticky_q, sticky_d;
    logic          err_d;
    logic          short_frm;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (d_de) begin
            if (col_q != CNT_MAX) col_d = col_q + 1'b1;
        end else if (de_fall || vs_rise) begin
            col_d = '0;
        end
        if (vs_rise) begin
            row_d = '0;
        end else if (de_fall && row_q != CNT_MAX) begin
            row_d = row_q + 1'b1;
        end
    end

    // A load landing on the vsync edge itself applies to the frame starting now.
    always_comb begin
        pend_d  = pend_q;
        pmode_d = pmode_q;
        mode_d  = mode_q;
        if (cfg_load) begin
            pend_d  = 1'b1;
            pmode_d = mode_e'(cfg_mode);
        end
        if (vs_rise) begin
            pend_d = 1'b0;
            if (cfg_load)    mode_d = mode_e'(cfg_mode);
            else if (pend_q) mode_d = pmode_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        short_frm = 1'b0;
        sticky_d  = sticky_q;
        unique case (state_q)
            IDLE: if (vs_rise) state_d = FRAME;
            FRAME: begin
                if (vs_rise) begin
                    short_frm = 1'b1;
                end else if (de_fall) begin
                    err_d = (col_q != H_LEN);
                    if (row_q == V_LAST) state_d = DONE;
                end
            end
            DONE: state_d = WAIT;
            WAIT: if (vs_rise) state_d = FRAME;
            default: state_d = IDLE;
        endcase
        if (vs_rise) sticky_d = 1'b0;
        if (err_d || short_frm) sticky_d = 1'b1;
    end

    logic       border;
    logic [7:0] pix;
    logic       out_en;

    always_comb begin
        border = (row_q == '0) || (row_q == V_LAST) ||
                 (col_q == '0) || (col_q == H_LAST);
        pix = d_raw;
        unique case (mode_q)
            MODE_BYPASS:       pix = d_raw;
            MODE_MEDIAN:       pix = filt_data_i;
            MODE_BORDER_CONST: pix = border ? BORDER_VAL : filt_data_i;
            MODE_BORDER_RAW:   pix = border ? d_raw : filt_data_i;
            default:           pix = d_raw;
        endcase
    end

    // Pixels arriving outside a tracked frame (after reset, in WAIT) are blanked.
    assign out_en = d_de && ((state_q == FRAME) || vs_rise);

    logic          hs_q, vs_q, de_q, err_q;
    logic [7:0]    data_q;
    logic [CW-1:0] col_o_q, row_o_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev_q <= 1'b0;
            de_prev_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            mode_q    <= MODE_BYPASS;
            pmode_q   <= MODE_BYPASS;
            pend_q    <= 1'b0;
            state_q   <= IDLE;
            sticky_q  <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
            col_o_q   <= '0;
            row_o_q   <= '0;
        end else begin
            vs_prev_q <= d_vs;
            de_prev_q <= d_de;
            col_q     <= col_d;
            row_q     <= row_d;
            mode_q    <= mode_d;
            pmode_q   <= pmode_d;
            pend_q    <= pend_d;
            state_q   <= state_d;
            sticky_q  <= sticky_d;
            hs_q      <= d_hs;
            vs_q      <= d_vs;
            de_q      <= out_en;
            err_q     <= err_d;
            data_q    <= out_en ? pix : 8'h00;
            col_o_q   <= out_en ? col_q : '0;
            row_o_q   <= out_en ? row_q : '0;
        end
    end

    assign hsync_o    = hs_q;
    assign vsync_o    = vs_q;
    assign de_o       = de_q;
    assign data_o     = data_q;
    assign col_o      = col_o_q;
    assign row_o      = row_o_q;
    assign err_line   = err_q;
    assign err_sticky = sticky_q;
    assign frame_done = (state_q == DONE);
    assign busy       = (state_q == FRAME);

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Randomized frame-level bench for median_frame_ctrl with a slot-indexed reference model.
module tb_median_frame_ctrl;

    localparam int         H    = 8;
    localparam int         V    = 6;
    localparam int         LAT  = 3;
    localparam int         CW   = 12;
    localparam int         N    = 4096;
    localparam logic [7:0] BVAL = 8'h00;

    logic          clk = 1'b0;
    logic          rst;
    logic          hsync_i, vsync_i, de_i;
    logic [7:0]    data_i, filt_data_i;
    logic [1:0]    cfg_mode;
    logic          cfg_load;
    logic          hsync_o, vsync_o, de_o;
    logic [7:0]    data_o;
    logic [CW-1:0] col_o, row_o;
    logic          frame_done, err_line, err_sticky, busy;

    median_frame_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .PIPE_LAT(LAT),
        .BORDER_VAL(BVAL), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i),
        .data_i(data_i), .filt_data_i(filt_data_i),
        .cfg_mode(cfg_mode), .cfg_load(cfg_load),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
        .data_o(data_o), .col_o(col_o), .row_o(row_o),
        .frame_done(frame_done), .err_line(err_line),
        .err_sticky(err_sticky), .busy(busy)
    );

    always #5 clk = ~clk;

    int         cyc = -1;
    bit         exp_hs[N], exp_vs[N], exp_de[N];
    logic [7:0] exp_d[N];
    int         exp_col[N], exp_row[N];
    bit         ev_vs[N], ev_short[N], ev_err[N], ev_done[N], ev_rst[N];
    logic [7:0] in_f[N];
    int         zlo = -1, zhi = -1;

    bit         m_active = 0;
    bit         m_pend = 0;
    logic [1:0] m_pmode = 2'd0;
    logic [1:0] m_fmode = 2'd0;
    int         m_vstart = -100;
    logic [7:0] frame_key;
    bit         rst_req = 0;
    int         rst_left = 0;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s slot %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] pick(logic [1:0] m, int c, int r,
                                        logic [7:0] raw, logic [7:0] f);
        bit b;
        b = (r == 0) || (r == V - 1) || (c == 0) || (c == H - 1);
        case (m)
            2'd0:    return raw;
            2'd1:    return f;
            2'd2:    return b ? BVAL : f;
            default: return b ? raw : f;
        endcase
    endfunction

    task automatic step(bit hs, bit vs, bit de, bit cl, logic [1:0] cm,
                        int c, int r);
        logic [7:0] raw;
        @(posedge clk);
        cyc++;
        #1;
        if (rst_req) begin
            rst = 1'b1;
            rst_req = 0;
            rst_left = 2;
            ev_rst[cyc] = 1;
            zlo = cyc;
            zhi = cyc + 5;
            m_active = 0;
            m_pend = 0;
            m_fmode = 2'd0;
        end else if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) rst = 1'b0;
        end
        raw = 8'($urandom);
        hsync_i = hs;
        vsync_i = vs;
        de_i = de;
        data_i = raw;
        in_f[cyc] = raw ^ frame_key;
        filt_data_i = (cyc >= LAT) ? in_f[cyc-LAT] : 8'h00;
        cfg_load = cl;
        cfg_mode = cl ? cm : 2'($urandom);
        if (cl && !rst) begin
            m_pend = 1;
            m_pmode = cm;
        end
        if (cyc == m_vstart + 3) begin
            if (m_pend) m_fmode = m_pmode;
            m_pend = 0;
        end
        exp_hs[cyc+4] = hs;
        exp_vs[cyc+4] = vs;
        exp_de[cyc+4] = de && m_active;
        exp_d[cyc+4] = (de && m_active) ? pick(m_fmode, c, r, raw, in_f[cyc]) : 8'h00;
        exp_col[cyc+4] = c;
        exp_row[cyc+4] = r;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 2'd0, 0, 0);
    endtask

    task automatic frame(int nlines, int short_row, int cfg_row,
                         logic [1:0] cfg_m, bit cfg_at_vs, int rst_row);
        int len;
        frame_key = 8'($urandom);
        m_vstart = cyc + 1;
        if (m_active) ev_short[m_vstart+4] = 1;
        ev_vs[m_vstart+4] = 1;
        m_active = 1;
        for (int i = 0; i < 6; i++) begin
            step(0, i < 2, 0, cfg_at_vs && i == 3, cfg_m, 0, 0);
        end
        for (int r = 0; r < nlines; r++) begin
            len = (r == short_row) ? H - 1 : H;
            for (int c = 0; c < len; c++) begin
                if (r == rst_row && c == 3) rst_req = 1;
                step(0, 0, 1, r == cfg_row && c == 2, cfg_m, c, r);
            end
            if (m_active && len != H) ev_err[cyc+5] = 1;
            if (m_active && r == V - 1) begin
                ev_done[cyc+5] = 1;
                m_active = 0;
            end
            step(1, 0, 0, 0, 2'd0, 0, 0);
            step(1, 0, 0, 0, 2'd0, 0, 0);
            idle(2);
        end
        idle(3);
    endtask

    bit lv_busy = 0;
    bit lv_sticky = 0;

    always @(negedge clk) begin
        int  s;
        bit  zw;
        s = cyc;
        if (s >= 0 && s < N) begin
            if (ev_rst[s]) begin
                lv_busy = 0;
                lv_sticky = 0;
            end
            if (ev_vs[s]) begin
                lv_busy = 1;
                lv_sticky = 0;
            end
            if (ev_short[s] || ev_err[s]) lv_sticky = 1;
            if (ev_done[s]) lv_busy = 0;
            zw = (s >= zlo) && (s <= zhi);
            check("hsync_o", hsync_o, zw ? 1'b0 : exp_hs[s]);
            check("vsync_o", vsync_o, zw ? 1'b0 : exp_vs[s]);
            check("de_o", de_o, zw ? 1'b0 : exp_de[s]);
            check("data_o", data_o, zw ? 8'h00 : exp_d[s]);
            if (!zw && exp_de[s]) begin
                check("col_o", col_o, exp_col[s]);
                check("row_o", row_o, exp_row[s]);
            end
            check("frame_done", frame_done, ev_done[s]);
            check("err_line", err_line, ev_err[s]);
            check("err_sticky", err_sticky, lv_sticky);
            check("busy", busy, lv_busy);
        end
    end

    initial begin
        rst = 1'b1;
        rst_left = 3;
        hsync_i = 0;
        vsync_i = 0;
        de_i = 0;
        data_i = 0;
        filt_data_i = 0;
        cfg_mode = 0;
        cfg_load = 0;
        frame_key = 0;
        idle(6);
        frame(V, -1, 2, 2'd1, 0, -1);
        frame(V, -1, 3, 2'd2, 0, -1);
        frame(V, 2, 1, 2'd3, 0, -1);
        frame(V, -1, -1, 2'd0, 0, -1);
        frame(V, -1, -1, 2'($urandom), 1, -1);
        frame(4, -1, -1, 2'd0, 0, -1);
        frame(V, -1, -1, 2'd0, 0, -1);
        frame(V, -1, 4, 2'd2, 0, 3);
        frame(V, -1, -1, 2'd0, 0, -1);
        for (int k = 0; k < 4; k++) begin
            frame(V,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, V - 1)) : -1,
                  int'($urandom_range(0, V - 1)),
                  2'($urandom),
                  1'($urandom_range(0, 1)),
                  -1);
        end
        idle(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
